// File: rtl/esp_resp_parser_pkg.sv
// Shared constants, FSM state encoding and helpers for the ESP8266 response parser.
package esp_resp_parser_pkg;

  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_NINE = 8'h39;

  // Strings packed MSB-first: character 0 lives in the top byte.
  localparam logic [15:0] STR_OK      = 16'h4F4B;              // "OK"
  localparam logic [55:0] STR_CONNECT = 56'h434F4E4E454354;    // "CONNECT"

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_GOT_CR  = 2'd1,
    S_OVF     = 2'd2,
    S_EVAL    = 2'd3
  } state_t;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASCII_ZERO) && (b <= ASCII_NINE);
  endfunction

endpackage

// File: rtl/resp_line_buf.sv
// Line buffer for one response line: byte array, write pointer/length and
// combinational "OK" / "CONNECT" / all-digits matchers.
module resp_line_buf
  import esp_resp_parser_pkg::*;
#(
  parameter int MAX_LEN    = 16,
  parameter int NUM_DIGITS = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clr,
  input  logic                           wr_en,
  input  logic [7:0]                     wr_data,
  output logic [$clog2(MAX_LEN+1)-1:0]   len,
  output logic                           is_ok,
  output logic                           is_conn,
  output logic                           is_digits
);
  localparam int LW = $clog2(MAX_LEN + 1);

  logic [7:0]    mem_r [MAX_LEN];
  logic [LW-1:0] len_r;
  logic          is_ok_s;
  logic          is_conn_s;
  logic          is_dig_s;

  // Byte storage and length; the caller never writes once len reaches MAX_LEN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_r <= '0;
      for (int i = 0; i < MAX_LEN; i++) mem_r[i] <= 8'd0;
    end else if (clr) begin
      len_r <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        if (len_r == LW'(i)) mem_r[i] <= wr_data;
      end
      len_r <= len_r + LW'(1);
    end
  end

  // Exact-match and numeric-shape classification of the stored line.
  always_comb begin
    is_ok_s   = (len_r == LW'(2)) && (mem_r[0] == STR_OK[15:8]) && (mem_r[1] == STR_OK[7:0]);
    is_conn_s = (len_r == LW'(7));
    for (int i = 0; i < 7; i++) begin
      is_conn_s = is_conn_s && (mem_r[i] == STR_CONNECT[8*(6-i) +: 8]);
    end
    is_dig_s = (len_r != '0) && (len_r <= LW'(NUM_DIGITS));
    for (int i = 0; i < MAX_LEN; i++) begin
      if (LW'(i) < len_r) is_dig_s = is_dig_s && is_digit(mem_r[i]);
      else                is_dig_s = is_dig_s;
    end
  end

  assign len       = len_r;
  assign is_ok     = is_ok_s;
  assign is_conn   = is_conn_s;
  assign is_digits = is_dig_s;

endmodule

// File: rtl/esp_resp_parser.sv
// ESP8266 response line parser: assembles CR-LF terminated lines from UART
// bytes and emits one-cycle OK / CONNECT / number / error pulses.
module esp_resp_parser
  import esp_resp_parser_pkg::*;
#(
  parameter int MAX_LEN    = 16,
  parameter int NUM_DIGITS = 3
) (
  input  logic       iCLK,
  input  logic       RST,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output logic       ok_pulse,
  output logic       conn_pulse,
  output logic       num_valid,
  output logic [7:0] num_value,
  output logic       err_pulse,
  output logic       err_ovf,
  output logic       busy
);
  localparam int LW = $clog2(MAX_LEN + 1);

  state_t        state_r, state_s;
  logic [7:0]    skid_r, skid_s;
  logic          skid_vld_r, skid_vld_s;
  logic          ovf_r, ovf_s;
  logic          ferr_r, ferr_s;
  logic [9:0]    acc_r, acc_s;
  logic          ok_r, ok_s, conn_r, conn_s, num_r, num_s, err_r, err_s, err_ovf_r, err_ovf_s;
  logic [7:0]    num_value_r, num_value_s;
  logic          busy_r, busy_s;
  logic          in_vld_s;
  logic [7:0]    in_byte_s;
  logic          buf_wr_s, buf_clr_s;
  logic [LW-1:0] len_s;
  logic          is_ok_s, is_conn_s, is_dig_s;
  logic [13:0]   acc_mul_s;
  logic [9:0]    acc_sat_s;

  resp_line_buf #(.MAX_LEN(MAX_LEN), .NUM_DIGITS(NUM_DIGITS)) u_buf (
    .clk       (iCLK),
    .rst       (RST),
    .clr       (buf_clr_s),
    .wr_en     (buf_wr_s),
    .wr_data   (in_byte_s),
    .len       (len_s),
    .is_ok     (is_ok_s),
    .is_conn   (is_conn_s),
    .is_digits (is_dig_s)
  );

  // Decimal accumulator step, saturating at the 10-bit ceiling.
  always_comb begin
    acc_mul_s = ({4'd0, acc_r} * 14'd10) + {10'd0, in_byte_s[3:0]};
    if (acc_mul_s > 14'd1023) acc_sat_s = 10'd1023;
    else                      acc_sat_s = acc_mul_s[9:0];
  end

  // Next-state, skid handling and result classification.
  always_comb begin
    state_s     = state_r;
    skid_s      = skid_r;
    skid_vld_s  = skid_vld_r;
    ovf_s       = ovf_r;
    ferr_s      = ferr_r;
    acc_s       = acc_r;
    buf_wr_s    = 1'b0;
    buf_clr_s   = 1'b0;
    ok_s        = 1'b0;
    conn_s      = 1'b0;
    num_s       = 1'b0;
    err_s       = 1'b0;
    err_ovf_s   = 1'b0;
    num_value_s = num_value_r;
    if (skid_vld_r) begin
      in_vld_s  = 1'b1;
      in_byte_s = skid_r;
    end else begin
      in_vld_s  = rx_valid;
      in_byte_s = rx_byte;
    end
    case (state_r)
      S_EVAL: begin
        buf_clr_s = 1'b1;
        ovf_s     = 1'b0;
        ferr_s    = 1'b0;
        acc_s     = 10'd0;
        state_s   = S_COLLECT;
        if (ovf_r) begin
          err_s     = 1'b1;
          err_ovf_s = 1'b1;
        end else if (ferr_r) begin
          err_s = 1'b1;
        end else if (len_s == '0) begin
          err_s = 1'b0;
        end else if (is_ok_s) begin
          ok_s = 1'b1;
        end else if (is_conn_s) begin
          conn_s = 1'b1;
        end else if (is_dig_s && (acc_r <= 10'd255)) begin
          num_s       = 1'b1;
          num_value_s = acc_r[7:0];
        end else begin
          err_s = 1'b1;
        end
        // A byte landing here is parked; a second one is lost and spoils the next line.
        if (rx_valid) begin
          if (skid_vld_r) begin
            ferr_s = 1'b1;
          end else begin
            skid_s     = rx_byte;
            skid_vld_s = 1'b1;
          end
        end else begin
          skid_vld_s = skid_vld_r;
        end
      end
      default: begin
        if (skid_vld_r) begin
          if (rx_valid) begin
            skid_s     = rx_byte;
            skid_vld_s = 1'b1;
          end else begin
            skid_vld_s = 1'b0;
          end
        end else begin
          skid_vld_s = 1'b0;
        end
        if (in_vld_s) begin
          case (state_r)
            S_COLLECT: begin
              if (in_byte_s == ASCII_CR) begin
                state_s = S_GOT_CR;
              end else if (in_byte_s == ASCII_LF) begin
                state_s = S_EVAL;
              end else if (len_s == LW'(MAX_LEN)) begin
                ovf_s   = 1'b1;
                state_s = S_OVF;
              end else begin
                buf_wr_s = 1'b1;
                if (is_digit(in_byte_s)) acc_s = acc_sat_s;
                else                     acc_s = acc_r;
              end
            end
            S_OVF: begin
              if (in_byte_s == ASCII_LF) state_s = S_EVAL;
              else                       state_s = S_OVF;
            end
            S_GOT_CR: begin
              if (in_byte_s == ASCII_LF) begin
                state_s = S_EVAL;
              end else if (in_byte_s == ASCII_CR) begin
                state_s = S_GOT_CR;
              end else begin
                // Stray byte after CR: fail this line, replay the byte as the next line's first.
                ferr_s     = 1'b1;
                state_s    = S_EVAL;
                skid_vld_s = 1'b1;
                if (skid_vld_r) skid_s = skid_r;
                else            skid_s = in_byte_s;
              end
            end
            default: state_s = S_COLLECT;
          endcase
        end else begin
          state_s = state_r;
        end
      end
    endcase
  end

  assign busy_s = !((state_s == S_COLLECT) && (buf_clr_s || ((len_s == '0) && !buf_wr_s)));

  // State and registered outputs.
  always_ff @(posedge iCLK or posedge RST) begin
    if (RST) begin
      state_r     <= S_COLLECT;
      skid_r      <= 8'd0;
      skid_vld_r  <= 1'b0;
      ovf_r       <= 1'b0;
      ferr_r      <= 1'b0;
      acc_r       <= 10'd0;
      ok_r        <= 1'b0;
      conn_r      <= 1'b0;
      num_r       <= 1'b0;
      err_r       <= 1'b0;
      err_ovf_r   <= 1'b0;
      num_value_r <= 8'd0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      skid_r      <= skid_s;
      skid_vld_r  <= skid_vld_s;
      ovf_r       <= ovf_s;
      ferr_r      <= ferr_s;
      acc_r       <= acc_s;
      ok_r        <= ok_s;
      conn_r      <= conn_s;
      num_r       <= num_s;
      err_r       <= err_s;
      err_ovf_r   <= err_ovf_s;
      num_value_r <= num_value_s;
      busy_r      <= busy_s;
    end
  end

  assign ok_pulse   = ok_r;
  assign conn_pulse = conn_r;
  assign num_valid  = num_r;
  assign num_value  = num_value_r;
  assign err_pulse  = err_r;
  assign err_ovf    = err_ovf_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_esp_resp_parser.sv
// Scoreboard bench for esp_resp_parser: directed lines push expected pulses,
// a negedge monitor pops and compares kind, err_ovf, num_value and latency.
module tb_esp_resp_parser;

  localparam logic [3:0] K_NONE = 4'b0000;
  localparam logic [3:0] K_OK   = 4'b1000;
  localparam logic [3:0] K_CONN = 4'b0100;
  localparam logic [3:0] K_NUM  = 4'b0010;
  localparam logic [3:0] K_ERR  = 4'b0001;

  logic       iCLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] rx_byte = 8'd0;
  logic       rx_valid = 1'b0;
  logic       ok_pulse, conn_pulse, num_valid, err_pulse, err_ovf, busy;
  logic [7:0] num_value;

  int asserts_n = 0;
  int fails_n   = 0;
  int cyc       = 0;

  typedef struct {
    logic [3:0] kind;
    logic [7:0] val;
    logic       ovf;
    int         cyc;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] exp_numval = 8'd0;

  esp_resp_parser #(.MAX_LEN(16), .NUM_DIGITS(3)) dut (
    .iCLK       (iCLK),
    .RST        (RST),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .ok_pulse   (ok_pulse),
    .conn_pulse (conn_pulse),
    .num_valid  (num_valid),
    .num_value  (num_value),
    .err_pulse  (err_pulse),
    .err_ovf    (err_ovf),
    .busy       (busy)
  );

  always #10 iCLK = ~iCLK;

  always @(posedge iCLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    asserts_n++;
    if (act !== req) begin
      fails_n++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Drive each byte of s for one cycle, then idle gap cycles; expectation tied to the last byte.
  task automatic send(input string s, input int gap, input logic [3:0] kind,
                      input logic [7:0] val, input logic ovf);
    for (int i = 0; i < s.len(); i++) begin
      if ((i == s.len() - 1) && (kind != K_NONE)) exp_q.push_back('{kind, val, ovf, cyc + 2});
      rx_byte  = s[i];
      rx_valid = 1'b1;
      @(negedge iCLK);
      rx_valid = 1'b0;
      repeat (gap) @(negedge iCLK);
    end
  endtask

  always @(negedge iCLK) begin : monitor
    exp_t e;
    if (!RST && (ok_pulse || conn_pulse || num_valid || err_pulse)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {28'd0, ok_pulse, conn_pulse, num_valid, err_pulse}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        if (e.kind == K_NUM) exp_numval = e.val;
        chk("pulse_kind", {28'd0, ok_pulse, conn_pulse, num_valid, err_pulse}, {28'd0, e.kind});
        chk("err_ovf", {31'd0, err_ovf}, {31'd0, e.ovf});
        chk("num_value", {24'd0, num_value}, {24'd0, exp_numval});
        chk("latency", cyc, e.cyc);
      end
    end
  end

  initial begin
    RST = 1'b1;
    repeat (3) @(negedge iCLK);
    chk("reset_outputs", {18'd0, ok_pulse, conn_pulse, num_valid, num_value, err_pulse, err_ovf, busy}, 32'd0);
    RST = 1'b0;
    @(negedge iCLK);

    // UART-paced OK line
    send("OK\r\n", 434, K_OK, 8'd0, 1'b0);

    send("CONNECT\r\n", 3, K_CONN, 8'd0, 1'b0);
    send("3\r\n", 3, K_NUM, 8'd3, 1'b0);
    send("OK\r\n", 3, K_OK, 8'd0, 1'b0);

    send("255\r\n", 3, K_NUM, 8'd255, 1'b0);
    send("256\r\n", 3, K_ERR, 8'd0, 1'b0);
    send("1234\r\n", 3, K_ERR, 8'd0, 1'b0);
    send("003\r\n", 3, K_NUM, 8'd3, 1'b0);

    send("\r\n", 3, K_NONE, 8'd0, 1'b0);
    send("OKX\r\n", 3, K_ERR, 8'd0, 1'b0);
    send("ok\r\n", 3, K_ERR, 8'd0, 1'b0);
    send("OK\r", 3, K_NONE, 8'd0, 1'b0);
    send("A", 3, K_ERR, 8'd0, 1'b0);
    send("\r\n", 3, K_ERR, 8'd0, 1'b0);
    send("OK\r\r\n", 3, K_OK, 8'd0, 1'b0);
    send("OK\n", 3, K_OK, 8'd0, 1'b0);

    // Overflow vs. exactly-full line
    for (int i = 0; i < 20; i++) send("A", 2, K_NONE, 8'd0, 1'b0);
    send("\r\n", 3, K_ERR, 8'd0, 1'b1);
    send("OK\r\n", 3, K_OK, 8'd0, 1'b0);
    send("ABCDEFGHIJKLMNOP\r\n", 2, K_ERR, 8'd0, 1'b0);

    // Reset mid-line discards the partial "CONN"
    send("CONN", 3, K_NONE, 8'd0, 1'b0);
    chk("busy_mid_line", {31'd0, busy}, 32'd1);
    RST = 1'b1;
    exp_numval = 8'd0;
    repeat (3) begin
      @(negedge iCLK);
      chk("reset_mid_line", {18'd0, ok_pulse, conn_pulse, num_valid, num_value, err_pulse, err_ovf, busy}, 32'd0);
    end
    RST = 1'b0;
    @(negedge iCLK);
    send("ECT\r\n", 3, K_ERR, 8'd0, 1'b0);

    // Back-to-back LF then 'O' goes through the skid register
    send("7\r\n", 0, K_NUM, 8'd7, 1'b0);
    send("O", 3, K_NONE, 8'd0, 1'b0);
    send("K\r\n", 3, K_OK, 8'd0, 1'b0);

    for (int i = 0; (i < 100) && (exp_q.size() != 0); i++) @(negedge iCLK);
    chk("queue_drained", exp_q.size(), 32'd0);
    repeat (5) @(negedge iCLK);
    chk("idle_after_test", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts_n, fails_n);
    $finish;
  end

endmodule
